// File: rtl/enable_stream_drain_pkg.sv
// Shared constants for the enable-gated pipeline tail and its drain buffer.
// Holds default widths and the pointer-width helper used by the buffer logic.
package enable_stream_drain_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 4;

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/enable_stream_drain_mem.sv
// Storage array for the drain buffer: one write port, one combinational read port.
// Contents are deliberately left unreset; occupancy is tracked by the top level.
module drain_fifo_mem
   import enable_stream_drain_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = ptr_width(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // NOTE: no reset on the array; stale words are never visible because M_valid gates them.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/enable_stream_drain.sv
// Drain buffer at the tail of an enable-gated pipeline: freezes the pipeline
// via CLK_en when full and presents words first-word-fall-through.
module enable_stream_drain
   import enable_stream_drain_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       CLK_in,
   input  logic                       RST_in,
   input  logic                       Flush,
   input  logic [WIDTH-1:0]           Pipe_data,
   input  logic                       Pipe_valid,
   output logic                       CLK_en,
   output logic [WIDTH-1:0]           M_data,
   output logic                       M_valid,
   input  logic                       M_ready,
   output logic [$clog2(DEPTH+1)-1:0] Count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_rd_data;

   // Enable and valid decode from the count register alone, so no input reaches them combinationally.
   assign CLK_en  = (r_count != CW'(DEPTH));
   assign M_valid = (r_count != '0);
   assign M_data  = M_valid ? w_rd_data : '0;
   assign Count   = r_count;

   assign w_push = CLK_en & Pipe_valid;
   assign w_pop  = M_valid & M_ready;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (Flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   drain_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .i_clk   (CLK_in),
      .i_we    (w_push & ~Flush),
      .i_waddr (r_wr_ptr),
      .i_wdata (Pipe_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

endmodule

// File: tb/tb_enable_stream_drain.sv
// Directed bench for enable_stream_drain (WIDTH=16, DEPTH=4): streaming, fill,
// drain from full, wrap with simultaneous push/pop, flush and async reset.
module tb_enable_stream_drain;

   logic        CLK_in;
   logic        RST_in;
   logic        Flush;
   logic [15:0] Pipe_data;
   logic        Pipe_valid;
   logic        CLK_en;
   logic [15:0] M_data;
   logic        M_valid;
   logic        M_ready;
   logic [2:0]  Count;

   int checks = 0;
   int passed = 0;

   enable_stream_drain #(
      .WIDTH (16),
      .DEPTH (4)
   ) dut (
      .CLK_in     (CLK_in),
      .RST_in     (RST_in),
      .Flush      (Flush),
      .Pipe_data  (Pipe_data),
      .Pipe_valid (Pipe_valid),
      .CLK_en     (CLK_en),
      .M_data     (M_data),
      .M_valid    (M_valid),
      .M_ready    (M_ready),
      .Count      (Count)
   );

   initial begin
      CLK_in = 1'b0;
      forever #5 CLK_in = ~CLK_in;
   end

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge CLK_in);
      #1;
   endtask

   task automatic test_reset();
      RST_in = 1'b1; Flush = 1'b0; Pipe_valid = 1'b0; Pipe_data = '0; M_ready = 1'b0;
      #2;
      checks++; if (Count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", Count); else passed++;
      checks++; if (M_valid !== 1'b0) $display("FAIL reset_mvalid got=%b exp=0", M_valid); else passed++;
      checks++; if (M_data !== 16'h0) $display("FAIL reset_mdata got=%h exp=0000", M_data); else passed++;
      checks++; if (CLK_en !== 1'b1) $display("FAIL reset_clken got=%b exp=1", CLK_en); else passed++;
      step();
      RST_in = 1'b0;
      #2;
   endtask

   task automatic test_streaming();
      M_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         Pipe_valid = 1'b1; Pipe_data = 16'(i);
         step();
         checks++;
         if (M_valid !== 1'b1 || M_data !== 16'(i))
            $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h", i, M_valid, M_data, 16'(i));
         else passed++;
         checks++; if (Count !== 3'd1) $display("FAIL stream_count%0d got=%0d exp=1", i, Count); else passed++;
      end
      Pipe_valid = 1'b0;
      step();
      checks++;
      if (Count !== 3'd0 || M_valid !== 1'b0 || M_data !== 16'h0)
         $display("FAIL stream_empty got c=%0d v=%b d=%h exp c=0 v=0 d=0000", Count, M_valid, M_data);
      else passed++;
   endtask

   task automatic test_fill();
      M_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         Pipe_valid = 1'b1; Pipe_data = 16'h0011 + 16'(i);
         step();
      end
      checks++; if (Count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", Count); else passed++;
      checks++; if (CLK_en !== 1'b0) $display("FAIL fill_clken got=%b exp=0", CLK_en); else passed++;
      Pipe_valid = 1'b1; Pipe_data = 16'h0015;
      step();
      step();
      checks++; if (Count !== 3'd4) $display("FAIL fill_blocked_count got=%0d exp=4", Count); else passed++;
      checks++; if (M_data !== 16'h0011) $display("FAIL fill_head got=%h exp=0011", M_data); else passed++;
   endtask

   task automatic test_drain_from_full();
      M_ready = 1'b1;
      checks++; if (M_data !== 16'h0011) $display("FAIL drain_pop_word got=%h exp=0011", M_data); else passed++;
      step();
      M_ready = 1'b0;
      checks++; if (Count !== 3'd3) $display("FAIL drain_count got=%0d exp=3", Count); else passed++;
      checks++; if (CLK_en !== 1'b1) $display("FAIL drain_clken got=%b exp=1", CLK_en); else passed++;
      step();
      Pipe_valid = 1'b0;
      checks++; if (Count !== 3'd4) $display("FAIL drain_refill_count got=%0d exp=4", Count); else passed++;
      M_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (M_data !== 16'h0012 + 16'(i))
            $display("FAIL drain_order%0d got=%h exp=%h", i, M_data, 16'h0012 + 16'(i));
         else passed++;
         step();
      end
      M_ready = 1'b0;
      checks++; if (M_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", M_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      M_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         Pipe_valid = 1'b1; Pipe_data = 16'h0021 + 16'(i);
         step();
      end
      checks++; if (Count !== 3'd2) $display("FAIL b2b_prefill got=%0d exp=2", Count); else passed++;
      M_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         Pipe_valid = 1'b1; Pipe_data = 16'h0023 + 16'(i);
         checks++;
         if (M_data !== 16'h0021 + 16'(i))
            $display("FAIL b2b_word%0d got=%h exp=%h", i, M_data, 16'h0021 + 16'(i));
         else passed++;
         step();
         checks++; if (Count !== 3'd2) $display("FAIL b2b_count%0d got=%0d exp=2", i, Count); else passed++;
      end
      Pipe_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (M_data !== 16'h0027 + 16'(i))
            $display("FAIL b2b_tail%0d got=%h exp=%h", i, M_data, 16'h0027 + 16'(i));
         else passed++;
         step();
      end
      M_ready = 1'b0;
      checks++; if (Count !== 3'd0) $display("FAIL b2b_empty got=%0d exp=0", Count); else passed++;
   endtask

   task automatic test_flush();
      M_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Pipe_valid = 1'b1; Pipe_data = 16'h0031 + 16'(i);
         step();
      end
      checks++; if (Count !== 3'd3) $display("FAIL flush_prefill got=%0d exp=3", Count); else passed++;
      Flush = 1'b1; Pipe_valid = 1'b1; Pipe_data = 16'h0034; M_ready = 1'b1;
      step();
      Flush = 1'b0; Pipe_valid = 1'b0; M_ready = 1'b0;
      checks++;
      if (Count !== 3'd0 || M_valid !== 1'b0 || M_data !== 16'h0 || CLK_en !== 1'b1)
         $display("FAIL flush_state got c=%0d v=%b d=%h en=%b exp c=0 v=0 d=0000 en=1",
                  Count, M_valid, M_data, CLK_en);
      else passed++;
      Pipe_valid = 1'b1; Pipe_data = 16'h0035;
      step();
      Pipe_valid = 1'b0;
      checks++;
      if (M_valid !== 1'b1 || M_data !== 16'h0035 || Count !== 3'd1)
         $display("FAIL flush_after got c=%0d v=%b d=%h exp c=1 v=1 d=0035", Count, M_valid, M_data);
      else passed++;
      M_ready = 1'b1;
      step();
      M_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         Pipe_valid = 1'b1; Pipe_data = 16'h0041 + 16'(i);
         step();
      end
      Pipe_valid = 1'b0;
      checks++; if (Count !== 3'd3) $display("FAIL areset_prefill got=%0d exp=3", Count); else passed++;
      #3;
      RST_in = 1'b1;
      #1;
      checks++;
      if (M_valid !== 1'b0 || Count !== 3'd0 || CLK_en !== 1'b1 || M_data !== 16'h0)
         $display("FAIL areset_immediate got c=%0d v=%b d=%h en=%b exp c=0 v=0 d=0000 en=1",
                  Count, M_valid, M_data, CLK_en);
      else passed++;
      #2;
      RST_in = 1'b0;
      Pipe_valid = 1'b1; Pipe_data = 16'h00AA;
      step();
      Pipe_valid = 1'b0;
      checks++;
      if (M_valid !== 1'b1 || M_data !== 16'h00AA || Count !== 3'd1)
         $display("FAIL areset_push got c=%0d v=%b d=%h exp c=1 v=1 d=00aa", Count, M_valid, M_data);
      else passed++;
      M_ready = 1'b1;
      step();
      M_ready = 1'b0;
      checks++; if (M_valid !== 1'b0) $display("FAIL areset_pop got=%b exp=0", M_valid); else passed++;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_fill();
      test_drain_from_full();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
